// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  f_req;
    logic [DATA_WIDTH-1:0] f_addr;
    logic                  f_ready;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [2:0]            d_width;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_width;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  stall_f;
    logic                  stall_d;
    logic                  err;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_width,
               mem_ready, mem_rdata,
        output f_ready, f_rdata, d_ready, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_width,
               stall_f, stall_d, err
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_width,
               mem_ready, mem_rdata,
        input  f_ready, f_rdata, d_ready, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_width,
               stall_f, stall_d, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one shared memory port, with
// anti-starvation for fetch and a sticky timeout error.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 15
) (
    input logic            clk,
    input logic            rst,
    mem_arbiter_if.slave   bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam logic [2:0] WIDTH_WORD   = 3'b010;
    localparam logic [1:0] STARVE_LIMIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic [2:0]            width_q, width_d;
    logic                  err_q, err_d;

    logic                  busy_c;
    logic                  timeout_c;
    logic                  done_c;
    logic                  f_ready_c;
    logic                  d_ready_c;
    logic                  starve_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            width_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            width_q <= width_d;
            err_q   <= err_d;
        end
    end

    // A late mem_ready still beats the timeout in the same cycle.
    assign busy_c    = (state_q != S_IDLE);
    assign timeout_c = busy_c && !bus.mem_ready && (wait_q == WAIT_W'(MAX_WAIT));
    assign done_c    = bus.mem_ready || timeout_c;
    assign starve_c  = bus.f_req && (dcnt_q == STARVE_LIMIT);

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        width_d = width_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.d_req && !starve_c) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    we_d    = bus.d_we;
                    width_d = bus.d_width;
                    dcnt_d  = bus.f_req ? dcnt_q + 2'd1 : 2'd0;
                end else if (bus.f_req) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                    addr_d  = bus.f_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    width_d = WIDTH_WORD;
                    dcnt_d  = 2'd0;
                end else begin
                    dcnt_d  = 2'd0;
                end
            end
            S_FETCH, S_DATA: begin
                if (done_c) begin
                    state_d = S_IDLE;
                    if (timeout_c) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready pulses are suppressed while reset is asserted.
    assign f_ready_c = rst && (state_q == S_FETCH) && done_c;
    assign d_ready_c = rst && (state_q == S_DATA) && done_c;

    assign bus.f_ready   = f_ready_c;
    assign bus.d_ready   = d_ready_c;
    assign bus.f_rdata   = timeout_c ? '0 : bus.mem_rdata;
    assign bus.d_rdata   = timeout_c ? '0 : bus.mem_rdata;

    assign bus.mem_req   = busy_c;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_width = width_q;

    assign bus.stall_f   = bus.f_req & ~f_ready_c;
    assign bus.stall_d   = bus.d_req & ~d_ready_c;
    assign bus.err       = err_q;
endmodule
